// File: rtl/mem_pkg.sv
// Shared store-path definitions: size codes,
// byte-enable constants and buffer entry layout.
package mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [3:0] BE_ALL = 4'b1111;

  localparam int ENTRY_W = 30 + 32 + 4;

  typedef struct packed {
    logic [29:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } sb_entry_t;

endpackage

// File: rtl/store_lane_pack.sv
// Narrows a register value onto little-endian
// byte lanes and flags misaligned/illegal stores.
module store_lane_pack
  import mem_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_data,
  output logic [31:0] o_wdata,
  output logic [3:0]  o_be,
  output logic        o_illegal
);

  // Lane replication, enables and alignment check
  always_comb begin
    o_wdata   = i_data;
    o_be      = '0;
    o_illegal = 1'b0;
    unique case (1'b1)
      (i_size == SZ_BYTE): begin
        o_wdata = {4{i_data[7:0]}};
        o_be    = 4'b0001 << i_addr_lo;
      end
      (i_size == SZ_HALF): begin
        o_wdata   = {2{i_data[15:0]}};
        o_be      = i_addr_lo[1] ? 4'b1100
                                 : 4'b0011;
        o_illegal = i_addr_lo[0];
      end
      (i_size == SZ_WORD): begin
        o_wdata   = i_data;
        o_be      = BE_ALL;
        o_illegal = |i_addr_lo;
      end
      default: begin
        o_illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/store_buffer.sv
// In-order store queue between MEM and data
// memory, with word-granular load hazard check.
module store_buffer
  import mem_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        st_valid,
  output logic        st_ready,
  input  logic [1:0]  st_size,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  output logic        st_misalign,
  input  logic        ld_check,
  input  logic [31:0] ld_addr,
  output logic        ld_hazard,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  output logic        empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  sb_entry_t     r_mem [DEPTH];

  logic [31:0]    w_wdata;
  logic [3:0]     w_be;
  logic           w_illegal;
  logic           w_full;
  logic           w_empty;
  logic           w_enq;
  logic           w_deq;
  sb_entry_t      w_new;
  sb_entry_t      w_head;
  logic [DEPTH-1:0] w_match;
  logic           w_unused_ld;

  store_lane_pack u_pack (
    .i_size    (st_size),
    .i_addr_lo (st_addr[1:0]),
    .i_data    (st_data),
    .o_wdata   (w_wdata),
    .o_be      (w_be),
    .o_illegal (w_illegal)
  );

  assign w_full  = (r_count == (AW+1)'(DEPTH));
  assign w_empty = (r_count == '0);

  assign st_ready    = ~w_full;
  assign empty       = w_empty;
  assign mem_valid   = ~w_empty;
  assign st_misalign = st_valid & w_illegal;

  assign w_enq = st_valid & ~w_full & ~w_illegal;
  assign w_deq = mem_valid & mem_ready;

  assign w_new.addr  = st_addr[31:2];
  assign w_new.wdata = w_wdata;
  assign w_new.be    = w_be;

  assign w_head    = r_mem[r_rptr];
  assign mem_addr  = {w_head.addr, 2'b00};
  assign mem_wdata = w_head.wdata;
  assign mem_be    = w_head.be;

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_enq) r_wptr <= r_wptr + 1'b1;
      if (w_deq) r_rptr <= r_rptr + 1'b1;
      unique case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage, written at the tail
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++)
        r_mem[i] <= '0;
    end else if (w_enq) begin
      r_mem[r_wptr] <= w_new;
    end
  end

  // An entry is live if it sits within count
  // slots of the head; compare word addresses
  for (genvar g = 0; g < DEPTH; g++) begin : g_hz
    logic [AW-1:0] w_off;
    logic          w_vld;
    assign w_off = AW'(g) - r_rptr;
    assign w_vld = ({1'b0, w_off} < r_count);
    assign w_match[g] = w_vld &
      (r_mem[g].addr == ld_addr[31:2]);
  end

  assign ld_hazard   = ld_check & |w_match;
  assign w_unused_ld = ^ld_addr[1:0];

endmodule

// File: tb/tb_store_buffer.sv
// Directed self-checking bench for store_buffer.
// Inputs change at posedge+1, checks at posedge+2.
module tb_store_buffer;

  logic        clk;
  logic        rst_n;
  logic        st_valid;
  logic        st_ready;
  logic [1:0]  st_size;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        st_misalign;
  logic        ld_check;
  logic [31:0] ld_addr;
  logic        ld_hazard;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        empty;

  int n_run;
  int n_fail;

  logic [31:0] q_addr [$];
  logic [31:0] q_data [$];

  store_buffer #(.DEPTH(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .st_valid    (st_valid),
    .st_ready    (st_ready),
    .st_size     (st_size),
    .st_addr     (st_addr),
    .st_data     (st_data),
    .st_misalign (st_misalign),
    .ld_check    (ld_check),
    .ld_addr     (ld_addr),
    .ld_hazard   (ld_hazard),
    .mem_valid   (mem_valid),
    .mem_ready   (mem_ready),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_be      (mem_be),
    .empty       (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [1:0] sz,
                     input logic [31:0] a,
                     input logic [31:0] d);
    st_valid = 1'b1;
    st_size  = sz;
    st_addr  = a;
    st_data  = d;
  endtask

  initial begin
    n_run     = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    st_valid  = 1'b0;
    st_size   = 2'b00;
    st_addr   = '0;
    st_data   = '0;
    ld_check  = 1'b0;
    ld_addr   = '0;
    mem_ready = 1'b0;
    #2;
    chk("rst_mvalid", 32'(mem_valid), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_ready", 32'(st_ready), 32'd1);
    chk("rst_maddr", mem_addr, 32'h0);
    chk("rst_wdata", mem_wdata, 32'h0);
    chk("rst_be", 32'(mem_be), 32'h0);
    tick();
    rst_n = 1'b1;
    tick();

    // byte store, held, then drained
    put(2'b00, 32'h1003, 32'h0000_00A5);
    #1;
    chk("b_misal", 32'(st_misalign), 32'd0);
    tick();
    st_valid = 1'b0;
    #1;
    chk("b_valid", 32'(mem_valid), 32'd1);
    chk("b_addr", mem_addr, 32'h1000);
    chk("b_wdata", mem_wdata, 32'hA5A5A5A5);
    chk("b_be", 32'(mem_be), 32'h8);
    tick();
    chk("b_hold", mem_addr, 32'h1000);
    chk("b_holdv", 32'(mem_valid), 32'd1);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    #1;
    chk("b_drain", 32'(empty), 32'd1);
    chk("b_dvalid", 32'(mem_valid), 32'd0);

    // halfword store
    put(2'b01, 32'h2002, 32'h1234BEEF);
    tick();
    st_valid = 1'b0;
    #1;
    chk("h_wdata", mem_wdata, 32'hBEEFBEEF);
    chk("h_be", 32'(mem_be), 32'hC);
    chk("h_addr", mem_addr, 32'h2000);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;

    // illegal stores
    put(2'b01, 32'h2001, 32'h55);
    #1;
    chk("h_misal", 32'(st_misalign), 32'd1);
    tick();
    chk("h_mis_emp", 32'(empty), 32'd1);
    put(2'b10, 32'h2002, 32'h55);
    #1;
    chk("w_misal", 32'(st_misalign), 32'd1);
    tick();
    chk("w_mis_emp", 32'(empty), 32'd1);
    put(2'b11, 32'h2000, 32'h55);
    #1;
    chk("sz3_misal", 32'(st_misalign), 32'd1);
    tick();
    chk("sz3_emp", 32'(empty), 32'd1);
    st_valid = 1'b0;
    #1;
    chk("nv_misal", 32'(st_misalign), 32'd0);

    // byte enables across all offsets
    mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      put(2'b00, 32'h40 + 32'(i), 32'h5A + 32'(i));
      tick();
      chk("bo_be", 32'(mem_be), 32'(4'b0001 << i));
      chk("bo_addr", mem_addr, 32'h40);
      chk("bo_data", mem_wdata,
          {4{8'(8'h5A + i)}});
    end
    st_valid = 1'b0;
    tick();
    mem_ready = 1'b0;
    #1;
    chk("bo_empty", 32'(empty), 32'd1);

    // fill to full with memory stalled
    for (int i = 0; i < 4; i++) begin
      put(2'b10, 32'(i * 4), 32'hA0 + 32'(i));
      tick();
    end
    chk("f_ready", 32'(st_ready), 32'd0);
    chk("f_head", mem_addr, 32'h0);
    put(2'b10, 32'h10, 32'hA4);
    tick();
    chk("f_held", 32'(st_ready), 32'd0);
    chk("f_head2", mem_addr, 32'h0);
    mem_ready = 1'b1;
    tick();
    chk("f_rdy_back", 32'(st_ready), 32'd1);
    chk("f_d1", mem_addr, 32'h4);
    chk("f_d1w", mem_wdata, 32'hA1);
    tick();
    st_valid = 1'b0;
    chk("f_d2", mem_addr, 32'h8);
    tick();
    chk("f_d3", mem_addr, 32'hC);
    chk("f_d3w", mem_wdata, 32'hA3);
    tick();
    chk("f_d4", mem_addr, 32'h10);
    chk("f_d4w", mem_wdata, 32'hA4);
    tick();
    chk("f_empty", 32'(empty), 32'd1);
    mem_ready = 1'b0;

    // two pending, then 12 enq+deq cycles
    q_addr.delete();
    q_data.delete();
    for (int i = 0; i < 2; i++) begin
      put(2'b10, 32'h100 + 32'(i * 4),
          32'h1111_0000 + 32'(i));
      q_addr.push_back(32'h100 + 32'(i * 4));
      q_data.push_back(32'h1111_0000 + 32'(i));
      tick();
    end
    mem_ready = 1'b1;
    for (int k = 2; k < 14; k++) begin
      put(2'b10, 32'h100 + 32'(k * 4),
          32'h1111_0000 + 32'(k));
      q_addr.push_back(32'h100 + 32'(k * 4));
      q_data.push_back(32'h1111_0000 + 32'(k));
      void'(q_addr.pop_front());
      void'(q_data.pop_front());
      tick();
      chk("s_addr", mem_addr, q_addr[0]);
      chk("s_data", mem_wdata, q_data[0]);
      chk("s_ready", 32'(st_ready), 32'd1);
      chk("s_nempty", 32'(empty), 32'd0);
    end
    st_valid = 1'b0;
    void'(q_addr.pop_front());
    tick();
    chk("s_last", mem_addr, q_addr[0]);
    tick();
    chk("s_empty", 32'(empty), 32'd1);
    mem_ready = 1'b0;

    // load hazard
    put(2'b10, 32'h3004, 32'hCAFE);
    tick();
    st_valid = 1'b0;
    ld_check = 1'b1;
    ld_addr  = 32'h3007;
    #1;
    chk("hz_hit", 32'(ld_hazard), 32'd1);
    ld_addr = 32'h3008;
    #1;
    chk("hz_miss", 32'(ld_hazard), 32'd0);
    ld_check = 1'b0;
    ld_addr  = 32'h3004;
    #1;
    chk("hz_nochk", 32'(ld_hazard), 32'd0);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    ld_check  = 1'b1;
    ld_addr   = 32'h3007;
    #1;
    chk("hz_drain", 32'(ld_hazard), 32'd0);
    ld_check = 1'b0;

    // async reset with three pending
    for (int i = 0; i < 3; i++) begin
      put(2'b10, 32'h500 + 32'(i * 4), 32'h77);
      tick();
    end
    st_valid = 1'b0;
    chk("r_pend", 32'(mem_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("r_mvalid", 32'(mem_valid), 32'd0);
    chk("r_empty", 32'(empty), 32'd1);
    chk("r_maddr", mem_addr, 32'h0);
    #2;
    rst_n = 1'b1;
    mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("r_quiet", 32'(mem_valid), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed",
             n_run, n_fail);
    $finish;
  end

endmodule
